// File: rtl/seq_hit_pkg.sv
// rtl/seq_hit_pkg.sv - handshake state encoding, default sizes and saturating add for sequence_hit_counter
package seq_hit_pkg;

    typedef enum logic [1:0] {
        H_IDLE      = 2'b00,
        H_WAIT_LOW  = 2'b01,
        H_WAIT_HIGH = 2'b10
    } hs_state_t;

    localparam int N_DEFAULT = 8;
    localparam int W_DEFAULT = 16;

    // Operands are widened to 32 bits so one function serves every N up to 31.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] maxv);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, maxv}) ? maxv : sum[31:0];
    endfunction

    function automatic logic sat_clamps(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] maxv);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum > {1'b0, maxv};
    endfunction

endpackage

// File: rtl/window_timer.sv
// rtl/window_timer.sv - free-running modulo-W cycle counter with a window-end tick
module window_timer #(
    parameter int W = 16
) (
    input  logic clock,
    input  logic reset_,
    output logic wend
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] wcnt;

    assign wend = (wcnt == CW'(W - 1));

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            wcnt <= '0;
        end else if (wend) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + CW'(1);
        end
    end

endmodule

// File: rtl/sequence_hit_counter.sv
// rtl/sequence_hit_counter.sv - windowed hit counter with dav_/rfd delivery; SEQUENCE_HIT_COUNTER_ACCUM_EN parks undelivered counts
module sequence_hit_counter
    import seq_hit_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         z,
    input  logic         rfd,
    output logic         dav_,
    output logic [N-1:0] out,
    output logic         lost
);

    localparam logic [31:0] MAXV = (32'd1 << N) - 32'd1;

    logic         wend;
    logic [N-1:0] hits;
    logic [N-1:0] snapshot;
    logic [N-1:0] out_d;
    logic         lost_d;
    logic         overrun;
    hs_state_t    state_q;
    hs_state_t    state_d;

    window_timer #(.W(W)) u_window_timer (
        .clock  (clock),
        .reset_ (reset_),
        .wend   (wend)
    );

    assign snapshot = N'(sat_add(32'(hits), 32'(z), MAXV));

    // A window closes undelivered unless the consumer is idle and ready at its end.
    assign overrun = wend && !(state_q == H_IDLE && rfd);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            hits <= '0;
        end else if (wend) begin
            hits <= '0;
        end else begin
            hits <= snapshot;
        end
    end

`ifdef SEQUENCE_HIT_COUNTER_ACCUM_EN
    logic [N-1:0] pend;
    logic [N-1:0] pend_d;
    logic         pvalid;
    logic         pvalid_d;
    logic [N-1:0] flush_add;
    logic [N-1:0] flush_val;
    logic         flush_ovf;
    logic [N-1:0] park_val;
    logic         park_ovf;

    assign flush_add = wend ? snapshot : '0;
    assign flush_val = N'(sat_add(32'(pend), 32'(flush_add), MAXV));
    assign flush_ovf = sat_clamps(32'(pend), 32'(flush_add), MAXV);
    assign park_val  = N'(sat_add(32'(pend), 32'(snapshot), MAXV));
    assign park_ovf  = sat_clamps(32'(pend), 32'(snapshot), MAXV);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            pend   <= '0;
            pvalid <= 1'b0;
        end else begin
            pend   <= pend_d;
            pvalid <= pvalid_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out;
        lost_d  = lost;
`ifdef SEQUENCE_HIT_COUNTER_ACCUM_EN
        pend_d   = pend;
        pvalid_d = pvalid;
`endif
        case (state_q)
            H_IDLE: begin
`ifdef SEQUENCE_HIT_COUNTER_ACCUM_EN
                if (rfd && pvalid) begin
                    out_d    = flush_val;
                    lost_d   = lost | flush_ovf;
                    pend_d   = '0;
                    pvalid_d = 1'b0;
                    state_d  = H_WAIT_LOW;
                end else if (wend && rfd) begin
                    out_d   = snapshot;
                    state_d = H_WAIT_LOW;
                end
`else
                if (wend && rfd) begin
                    out_d   = snapshot;
                    state_d = H_WAIT_LOW;
                end
`endif
            end
            H_WAIT_LOW: begin
                if (!rfd) begin
                    state_d = H_WAIT_HIGH;
                end
            end
            H_WAIT_HIGH: begin
                if (rfd) begin
                    state_d = H_IDLE;
                end
            end
            default: begin
                state_d = H_IDLE;
            end
        endcase

        if (overrun) begin
`ifdef SEQUENCE_HIT_COUNTER_ACCUM_EN
            pend_d   = park_val;
            pvalid_d = 1'b1;
            lost_d   = lost | park_ovf;
`else
            lost_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= H_IDLE;
            dav_    <= 1'b1;
            out     <= '0;
            lost    <= 1'b0;
        end else begin
            state_q <= state_d;
            dav_    <= (state_d != H_WAIT_LOW);
            out     <= out_d;
            lost    <= lost_d;
        end
    end

endmodule

// File: tb/tb_sequence_hit_counter.sv
// tb/tb_sequence_hit_counter.sv - randomized and directed check of sequence_hit_counter against a behavioural model
module tb_sequence_hit_counter;

    localparam int W = 16;
`ifdef SEQUENCE_HIT_COUNTER_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    typedef struct {
        int cyc;
        int hits;
        int phase;
        int out;
        int dav;
        int lost;
        int pend;
        int pvalid;
    } mstate_t;

    logic       clock = 1'b0;
    logic       reset_ = 1'b1;
    logic       z = 1'b0;
    logic       rfd = 1'b0;
    logic       dav8, lost8, dav4, lost4;
    logic [7:0] out8;
    logic [3:0] out4;
    bit         check_on = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    mstate_t    m8, m4;

    always #5 clock = ~clock;

    sequence_hit_counter #(.N(8), .W(W)) u_dut8 (
        .clock  (clock),
        .reset_ (reset_),
        .z      (z),
        .rfd    (rfd),
        .dav_   (dav8),
        .out    (out8),
        .lost   (lost8)
    );

    sequence_hit_counter #(.N(4), .W(W)) u_dut4 (
        .clock  (clock),
        .reset_ (reset_),
        .z      (z),
        .rfd    (rfd),
        .dav_   (dav4),
        .out    (out4),
        .lost   (lost4)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int smin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic mstate_t mreset();
        mstate_t s;
        s = '{cyc: 0, hits: 0, phase: 0, out: 0, dav: 1, lost: 0, pend: 0, pvalid: 0};
        return s;
    endfunction

    // One clock edge of the consumer-facing behaviour; phase 0 idle, 1 awaiting rfd low, 2 awaiting rfd high.
    function automatic mstate_t mstep(input mstate_t s, input int zi, input int ri, input int maxv);
        mstate_t n;
        bit      wend;
        int      snap;
        bit      taken;
        n     = s;
        wend  = (s.cyc == W - 1);
        snap  = smin(s.hits + zi, maxv);
        n.cyc  = wend ? 0 : s.cyc + 1;
        n.hits = wend ? 0 : snap;
        taken = 1'b0;
        if (s.phase == 0 && ri == 1) begin
            if (ACC && s.pvalid == 1) begin
                n.out    = smin(s.pend + (wend ? snap : 0), maxv);
                if (s.pend + (wend ? snap : 0) > maxv) n.lost = 1;
                n.pend   = 0;
                n.pvalid = 0;
                n.phase  = 1;
                taken    = wend;
            end else if (wend) begin
                n.out   = snap;
                n.phase = 1;
                taken   = 1'b1;
            end
        end else if (s.phase == 1 && ri == 0) begin
            n.phase = 2;
        end else if (s.phase == 2 && ri == 1) begin
            n.phase = 0;
        end
        if (wend && !taken) begin
            if (ACC) begin
                if (s.pend + snap > maxv) n.lost = 1;
                n.pend   = smin(s.pend + snap, maxv);
                n.pvalid = 1;
            end else begin
                n.lost = 1;
            end
        end
        n.dav = (n.phase == 1) ? 0 : 1;
        return n;
    endfunction

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m8 <= mreset();
            m4 <= mreset();
        end else begin
            m8 <= mstep(m8, int'(z), int'(rfd), 255);
            m4 <= mstep(m4, int'(z), int'(rfd), 15);
        end
    end

    always @(negedge clock) begin
        if (check_on && reset_) begin
            check_eq("model_dav8", int'(dav8), m8.dav);
            check_eq("model_out8", int'(out8), m8.out);
            check_eq("model_lost8", int'(lost8), m8.lost);
            check_eq("model_dav4", int'(dav4), m4.dav);
            check_eq("model_out4", int'(out4), m4.out);
            check_eq("model_lost4", int'(lost4), m4.lost);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_ = 1'b0;
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    task automatic cycle(input logic zz, input logic rr);
        z   = zz;
        rfd = rr;
        @(negedge clock);
    endtask

    initial begin
        #1 reset_ = 1'b0;
        #1;
        check_eq("reset_dav", int'(dav8), 1);
        check_eq("reset_out", int'(out8), 0);
        check_eq("reset_lost", int'(lost8), 0);
        @(negedge clock);
        reset_ = 1'b1;
        check_on = 1'b1;

        // Five hits including the final cycle of window 0, then a full handshake.
        do_reset();
        for (int i = 0; i < W; i++) cycle(i inside {1, 3, 5, 9, 15}, 1'b1);
        check_eq("t1_dav", int'(dav8), 0);
        check_eq("t1_out", int'(out8), 5);
        check_eq("t1_lost", int'(lost8), 0);
        cycle(1'b0, 1'b0);
        check_eq("t1_dav_release", int'(dav8), 1);
        cycle(1'b0, 1'b1);
        check_eq("t1_idle_dav", int'(dav8), 1);

        // Consumer never drops rfd: the second window arrives mid-handshake.
        do_reset();
        for (int i = 0; i < 2 * W; i++) cycle((i % W) inside {2, 6, 11}, 1'b1);
        check_eq("t2_lost", int'(lost8), ACC ? 0 : 1);
        check_eq("t2_out", int'(out8), 3);
        check_eq("t2_dav", int'(dav8), 0);

        // Every cycle a hit: the 4-bit instance saturates.
        do_reset();
        for (int i = 0; i < W; i++) cycle(1'b1, 1'b1);
        check_eq("t3_out4_sat", int'(out4), 15);
        check_eq("t3_out8", int'(out8), 16);
        check_eq("t3_lost4", int'(lost4), 0);

        // Asynchronous reset mid-window while dav_ is low.
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
        #2 reset_ = 1'b0;
        #1;
        check_eq("t4_dav", int'(dav8), 1);
        check_eq("t4_out", int'(out8), 0);
        check_eq("t4_lost", int'(lost8), 0);
        @(negedge clock);
        reset_ = 1'b1;
        for (int i = 0; i < W; i++) cycle(i == 4 || i == 15, 1'b1);
        check_eq("t4_recount", int'(out8), 2);

        // rfd low exactly at the window-1 end.
        do_reset();
        for (int i = 0; i < W; i++) cycle(i == 0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int i = 18; i < 2 * W - 1; i++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check_eq("t5_lost", int'(lost8), ACC ? 0 : 1);
        check_eq("t5_dav", int'(dav8), 1);
        check_eq("t5_out", int'(out8), 1);

        // Random traffic with a persistent, occasionally toggling rfd and rare resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rfd = ~rfd;
            z = 1'($urandom_range(1));
            if ($urandom_range(699) == 0) begin
                #3 reset_ = 1'b0;
                @(negedge clock);
                reset_ = 1'b1;
            end else begin
                @(negedge clock);
            end
        end

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_hit_counter.md
Name: sequence_hit_counter

Overview:
- Downstream consumer of the sequence recogniser's 1-bit Mealy output z.
- Counts recognised-sequence hits over fixed windows of W clock cycles.
- At each window end, delivers the hit count to a consumer over the dav_/rfd handshake.
- Flags windows that could not be delivered.

Parameters:
- N, 8: hit-count width; the count saturates at 2^N-1.
- W, 16: window length in clock cycles; must be 2 or more.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_  input  1  asynchronous reset, active-low.
- z  input  1  hit pulse from the recogniser; sampled on the rising edge of clock.
- rfd  input  1  consumer ready-for-data; 1 = ready.
- dav_  output  1  data available, active-low.
- out  output  N  hit count of the delivered window.
- lost  output  1  sticky flag; 1 = at least one window's count was discarded.

Behaviour:
- Reset (reset_=0, asynchronous, effective at once):
  - dav_=1, out=0, lost=0.
  - Window counter wcnt=0, hit counter hits=0, handshake state H_IDLE.
  - While reset_=0, all clock edges are ignored.
  - Reset mid-handshake or mid-window abandons it; there is no partial delivery.
- Window timing:
  - wcnt counts 0..W-1 and increments on every edge.
  - The edge where wcnt==W-1 is the window end (wend): wcnt wraps to 0 there.
- Hit counting:
  - On non-wend edges: hits <= sat(hits + z).
  - On a wend edge: snapshot = sat(hits + z), so a hit in the last cycle counts in the closing window; then hits <= 0.
  - sat() clamps to 2^N-1.
- Handshake states: H_IDLE (dav_=1), H_WAIT_LOW (dav_=0), H_WAIT_HIGH (dav_=1).
  - H_IDLE, wend, rfd==1: out <= snapshot, dav_ <= 0, go to H_WAIT_LOW. Delivery latency is 1 edge after the window closes.
  - H_IDLE, wend, rfd==0: snapshot discarded, lost <= 1.
  - H_WAIT_LOW: when rfd==0, dav_ <= 1 and go to H_WAIT_HIGH. out holds its value for the whole handshake.
  - H_WAIT_HIGH: when rfd==1, go to H_IDLE.
  - wend in H_WAIT_LOW or H_WAIT_HIGH: snapshot discarded, lost <= 1.
- Simultaneous events:
  - A handshake exit and a wend on the same edge: the wend is judged by the current state (pre-edge), so the window is lost.
  - lost is cleared only by reset.
- out changes only on a load.

Optional Feature:
- Macro: SEQUENCE_HIT_COUNTER_ACCUM_EN.
- When defined:
  - A pending register pend (N bits) and a pvalid bit are added; both reset to 0.
  - An undeliverable snapshot is not discarded: pend <= sat(pend + snapshot), pvalid <= 1.
  - On any edge in H_IDLE with rfd==1 and pvalid==1: out <= sat(pend + (wend ? snapshot : 0)), pend <= 0, pvalid <= 0, dav_ <= 0, go to H_WAIT_LOW.
  - lost is set only when a sat() in the pend path clamps.
- When undefined: behaviour exactly as above, with no pend or pvalid logic.

Decomposition:
- Package seq_hit_pkg holds:
  - Handshake state encoding: H_IDLE=2'b00, H_WAIT_LOW=2'b01, H_WAIT_HIGH=2'b10.
  - Default values of N and W.
  - The saturating-add function sat_add.
- One sub-module, window_timer:
  - Parameter W, ports clock and reset_.
  - Output wend is a 1-cycle tick while wcnt==W-1.
- Hit counting and the handshake FSM stay in the top level.

Test Plan (all with N=8, W=16):
1. Reset, rfd=1, z=1 on 5 cycles of window 0 (including cycle 15) -> after edge 16: dav_=0, out=5, lost=0. Set rfd=0 -> dav_=1 next edge; set rfd=1 -> H_IDLE.
2. rfd held 1 but never lowered, z=1 on 3 cycles per window -> window 0 delivered, out=3. Window 1 wend in H_WAIT_LOW -> lost=1, out stays 3, dav_ stays 0.
3. N=4 override, z=1 on all 16 cycles -> out=15 (saturated), lost=0.
4. reset_ pulsed low mid-window (cycle 7) while dav_=0 -> dav_=1, out=0, lost=0 immediately, with no clock edge. The next window counts from 0.
5. rfd=0 at the window-1 wend -> lost=1, no dav_ assertion.
6. With SEQUENCE_HIT_COUNTER_ACCUM_EN: window 0 = 2 hits delivered and held until the window-1 wend; window 1 = 4 hits, so pend=4. Complete the handshake -> next H_IDLE edge gives out=4, dav_=0, lost=0.
